// File: rtl/instr_fetch_issue_pkg.sv
// instr_fetch_issue_pkg: opcodes, instruction layout and fetch states
// shared between the fetch front end and control_fsm.
package instr_fetch_issue_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SLA  = 4'h6;
    localparam logic [3:0] OP_SRA  = 4'h7;
    localparam logic [3:0] OP_LI   = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_SUBI = 4'ha;
    localparam logic [3:0] OP_LWI  = 4'hb;
    localparam logic [3:0] OP_BLE  = 4'hc;
    localparam logic [3:0] OP_BGE  = 4'hd;
    localparam logic [3:0] OP_BEQ  = 4'he;
    localparam logic [3:0] OP_J    = 4'hf;

    // Instruction layout: [15:12] op, [11:8] op1, [7:4] op2, [3:0] op3.
    typedef struct packed {
        logic [3:0] op_code;
        logic [3:0] op1;
        logic [3:0] op2;
        logic [3:0] op3;
    } instr_t;

    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] ISSUE   = 2'd2;
    localparam logic [1:0] BR_WAIT = 2'd3;

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_BLE) || (op == OP_BGE) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/instr_fetch_issue_pc_counter.sv
// instr_fetch_issue_pc_counter: program counter with increment,
// in-page jump and full branch-target load.
module instr_fetch_issue_pc_counter #(
    parameter int pc_width = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                load_j,
    input  logic [11:0]         j_addr,
    input  logic                load_br,
    input  logic [pc_width-1:0] br_target,
    output logic [pc_width-1:0] pc
);

    localparam logic [pc_width-1:0] ONE = 1;

    // Branch target beats jump beats increment; wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= '0;
        end else if (load_br) begin
            pc <= br_target;
        end else if (load_j) begin
            pc <= {pc[pc_width-1:12], j_addr};
        end else if (inc) begin
            pc <= pc + ONE;
        end
    end

endmodule

// File: rtl/instr_fetch_issue.sv
// instr_fetch_issue: fetches, splits and issues 16-bit instructions.
// Define INSTR_COUNT_EN to add issue_count / stall_count outputs.
module instr_fetch_issue
    import instr_fetch_issue_pkg::*;
#(
    parameter int pc_width           = 16,
    parameter int instr_width        = 16,
    parameter int reg_file_addr_size = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          imem_req,
    output logic [pc_width-1:0]           imem_addr,
    input  logic [instr_width-1:0]        imem_rdata,
    input  logic                          imem_rvalid,
    output logic [3:0]                    op_code,
    output logic [reg_file_addr_size-1:0] op1,
    output logic [reg_file_addr_size-1:0] op2,
    output logic [reg_file_addr_size-1:0] op3,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    input  logic                          br_resolve,
    input  logic                          br_taken,
    input  logic [pc_width-1:0]           br_target,
`ifdef INSTR_COUNT_EN
    output logic [15:0]                   issue_count,
    output logic [15:0]                   stall_count,
`endif
    output logic [pc_width-1:0]           pc
);

    logic [1:0] state;
    logic       armed;
    instr_t     ir;
    logic       xfer;
    logic       is_j;

    // armed stays low for the first cycle out of reset so that
    // imem_req reads 0 right after reset and any stray response
    // from before reset lands while no fetch is outstanding.
    assign imem_req    = (state == FETCH) && armed;
    assign imem_addr   = pc;
    assign issue_valid = (state == ISSUE);
    assign xfer        = issue_valid && issue_ready;
    assign is_j        = (ir.op_code == OP_J);

    assign op_code = ir.op_code;
    assign op1     = ir.op1;
    assign op2     = ir.op2;
    assign op3     = ir.op3;

    instr_fetch_issue_pc_counter #(
        .pc_width(pc_width)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .inc      (xfer && !is_j),
        .load_j   (xfer && is_j),
        .j_addr   ({ir.op1, ir.op2, ir.op3}),
        .load_br  ((state == BR_WAIT) && br_resolve && br_taken),
        .br_target(br_target),
        .pc       (pc)
    );

    // Fetch sequencer; rvalid is only accepted while waiting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FETCH;
            armed <= 1'b0;
            ir    <= '0;
        end else begin
            armed <= 1'b1;
            unique case (state)
                FETCH: begin
                    if (armed) state <= WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        ir    <= instr_t'(imem_rdata[15:0]);
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_ready) begin
                        state <= is_branch(ir.op_code) ? BR_WAIT : FETCH;
                    end
                end
                BR_WAIT: begin
                    if (br_resolve) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef INSTR_COUNT_EN
    logic stalled;
    assign stalled = (issue_valid && !issue_ready) || (state == BR_WAIT);

    // Transfer count wraps; stall count saturates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            if (xfer) issue_count <= issue_count + 16'd1;
            if (stalled && (stall_count != 16'hffff)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_issue.sv
// tb_instr_fetch_issue: scoreboard bench with a program-order model
// of fetch addresses and issued fields.
module tb_instr_fetch_issue;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_rvalid;
    logic [3:0]  op_code;
    logic [3:0]  op1, op2, op3;
    logic        issue_valid;
    logic        issue_ready;
    logic        br_resolve;
    logic        br_taken;
    logic [15:0] br_target;
    logic [15:0] pc;
`ifdef INSTR_COUNT_EN
    logic [15:0] issue_count;
    logic [15:0] stall_count;
`endif

    instr_fetch_issue dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_rvalid(imem_rvalid),
        .op_code    (op_code),
        .op1        (op1),
        .op2        (op2),
        .op3        (op3),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .br_resolve (br_resolve),
        .br_taken   (br_taken),
        .br_target  (br_target),
`ifdef INSTR_COUNT_EN
        .issue_count(issue_count),
        .stall_count(stall_count),
`endif
        .pc         (pc)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem [0:65535];

    // driver state
    int          cyc = 0;
    int          lat = 0;
    int          br_cnt = 0;
    int          stall_left = 5;
    int          rst_phase = 0;
    logic [15:0] paddr;
    logic [16:0] dir_br [$];
    logic [16:0] brv;
    bit          directed;

    // model state
    logic [15:0] exp_fetch [$];
    logic [31:0] exp_issue [$];
    logic [31:0] cur;
    logic [15:0] e;
    logic [15:0] bnext;
    bit          br_pend = 0;
    bit          post_rst = 0;
    bit          bw, hs;
    int          idle = 0;
    int          hs_total = 0;
    int          hs_since_rst = 0;
    int          issue_m = 0;
    int          stall_m = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %h expected nothing", nm, act);
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        issue_ready = 1'b0;
        br_resolve = 1'b0;
        br_taken = 1'b0;
        br_target = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h0000] = 16'h0123;
        mem[16'h0001] = 16'hF004;
        mem[16'h0004] = 16'hE120;
        mem[16'h0040] = 16'hF004;
        mem[16'h0005] = 16'hC000;
        mem[16'h1003] = 16'hF0A5;
        mem[16'h10A5] = 16'hD000;
        mem[16'hFFFF] = 16'h0456;
        dir_br.push_back({1'b1, 16'h0040});
        dir_br.push_back({1'b0, 16'h0000});
        dir_br.push_back({1'b1, 16'h1003});
        dir_br.push_back({1'b1, 16'hFFFF});
    end

    // Stimulus: memory, consumer readiness, branch resolutions, reset.
    always @(negedge clk) begin
        cyc++;
        directed = (dir_br.size() > 0);
        imem_rvalid = 1'b0;
        br_resolve = 1'b0;
        br_taken = 1'($urandom);
        br_target = 16'($urandom);
        if (cyc == 3) rst = 1'b1;
        if (rst_phase == 2) begin
            rst = 1'b1;
            rst_phase = 3;
        end
        if (rst_phase == 1) begin
            rst = 1'b0;
            imem_rvalid = 1'b1;
            imem_rdata = 16'hF777;
            lat = 0;
            br_cnt = 0;
            rst_phase = 2;
        end else begin
            if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata = mem[paddr];
                end
            end
            if (imem_req && rst) begin
                paddr = imem_addr;
                lat = directed ? 1 : $urandom_range(1, 3);
                if (rst_phase == 0 && cyc >= 2500) rst_phase = 1;
            end
            if (directed) begin
                issue_ready = (stall_left == 0);
                if (issue_valid && stall_left > 0) stall_left--;
            end else begin
                issue_ready = ($urandom_range(0, 3) != 0);
            end
            if (br_cnt > 0) begin
                br_cnt--;
                if (br_cnt == 0) begin
                    br_resolve = 1'b1;
                    if (dir_br.size() > 0) begin
                        brv = dir_br.pop_front();
                        br_taken = brv[16];
                        br_target = brv[15:0];
                    end
                end
            end else if (!directed && $urandom_range(0, 9) == 0) begin
                br_resolve = 1'b1;
            end
            if (issue_valid && issue_ready &&
                op_code inside {4'hC, 4'hD, 4'hE}) begin
                br_cnt = directed ? 2 : $urandom_range(1, 4);
            end
        end
    end

    // Monitor and reference model, sampled 1 time unit after negedge.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            exp_fetch.delete();
            exp_issue.delete();
            exp_fetch.push_back(16'h0000);
            br_pend = 0;
            issue_m = 0;
            stall_m = 0;
            idle = 0;
            hs_since_rst = 0;
            post_rst = 1;
        end else begin
            if (post_rst) begin
                chk("rst_pc", pc, 0);
                chk("rst_imem_req", imem_req, 0);
                chk("rst_imem_addr", imem_addr, 0);
                chk("rst_valid", issue_valid, 0);
                chk("rst_fields", {op_code, op1, op2, op3}, 0);
                post_rst = 0;
            end
            bw = br_pend;
            hs = issue_valid && issue_ready;
`ifdef INSTR_COUNT_EN
            chk("issue_count", issue_count, 32'(issue_m[15:0]));
            chk("stall_count", stall_count, 32'(stall_m));
`endif
            if (br_pend && br_resolve) begin
                br_pend = 0;
                exp_fetch.push_back(br_taken ? br_target : bnext);
            end
            if (imem_req) begin
                if (exp_fetch.size() == 0) begin
                    fail("unexpected_fetch", imem_addr);
                end else begin
                    e = exp_fetch.pop_front();
                    chk("fetch_addr", imem_addr, e);
                    chk("fetch_pc", pc, e);
                    exp_issue.push_back({e, mem[e]});
                end
            end
            if (issue_valid) begin
                if (exp_issue.size() == 0) begin
                    fail("unexpected_issue", {op_code, op1, op2, op3});
                end else begin
                    cur = exp_issue[0];
                    chk("issue_fields", {op_code, op1, op2, op3},
                        cur[15:0]);
                    if (hs) begin
                        void'(exp_issue.pop_front());
                        hs_total++;
                        hs_since_rst++;
                        if (cur[15:12] == 4'hF) begin
                            exp_fetch.push_back({cur[31:28], cur[11:0]});
                        end else if (cur[15:12] >= 4'hC) begin
                            br_pend = 1;
                            bnext = cur[31:16] + 16'd1;
                        end else begin
                            exp_fetch.push_back(cur[31:16] + 16'd1);
                        end
                    end
                end
            end
            if (hs) issue_m++;
            if (((issue_valid && !issue_ready) || bw) && stall_m < 65535) begin
                stall_m++;
            end
            idle = hs ? 0 : idle + 1;
            if (idle > 100) begin
                fail("watchdog_no_issue", 32'(idle));
                idle = 0;
            end
        end
    end

    initial begin
        repeat (3000) @(posedge clk);
        #2;
        chk("progress_total", 32'(hs_total >= 100), 1);
        chk("progress_after_reset", 32'(hs_since_rst > 0), 1);
        chk("reset_test_done", 32'(rst_phase), 3);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
